// File: rtl/kyber_pmul_seq.sv
// Command sequencer that owns the KyberHPM1PE control pins: loads a and b, runs FNTT/PWM2/INTT, streams the product out.
// Optional done-timeout in the *_W states: define KYBER_SEQ_TIMEOUT_EN.
module kyber_pmul_seq #(
  parameter int PE_NUMBER    = 1,
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 4095,
  parameter int DATA_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_index,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_load_a_f,
  output logic              core_load_a_i,
  output logic              core_load_b_f,
  output logic              core_load_b_i,
  output logic              core_read_a,
  output logic              core_read_b,
  output logic              core_start_ab,
  output logic              core_start_fntt,
  output logic              core_start_pwm2,
  output logic              core_start_intt,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done
);

  if (PE_NUMBER != 1 || GAP_CYCLES < 1 || DONE_TIMEOUT < 1) begin : g_bad_cfg
    $error("kyber_pmul_seq: unsupported parameter set");
  end

`ifdef KYBER_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(GAP_CYCLES + DONE_TIMEOUT + 260);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(GAP_CYCLES + DONE_TIMEOUT - 1);
`else
  localparam int CNT_W = 9;
`endif
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(255);

  typedef enum logic [3:0] {
    S_IDLE, S_LDA, S_GAP, S_LDB, S_FNTT_P, S_FNTT_W, S_PWM_P, S_PWM_W,
    S_INTT_P, S_INTT_W, S_RD_P, S_RD_W, S_RD, S_FIN
  } state_t;

  state_t           state, state_d, gap_next, gap_next_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             mode_q, mode_d, err_q, err_d;
  logic             accept;
  logic [DATA_W-1:0] din_p0, rob_p0, rob_p1, rob_sel;
  logic [1:0]       rob_slot;
  logic             half_slot, direct_load;

  // Readout order interleaves the two halves: 0,128,1,129,...
  function automatic logic [7:0] read_order(input logic [7:0] k);
    return {k[0], k[7:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      gap_next <= S_IDLE;
      cnt      <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      gap_next <= gap_next_d;
      cnt      <= cnt_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d         = state;
    gap_next_d      = gap_next;
    cnt_d           = cnt + ONE_C;
    mode_d          = mode_q;
    err_d           = err_q;
    accept          = 1'b0;
    cmd_ready       = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    out_index       = '0;
    done            = 1'b0;
    core_load_a_f   = 1'b0;
    core_load_b_f   = 1'b0;
    core_load_b_i   = 1'b0;
    core_read_a     = 1'b0;
    core_start_ab   = 1'b0;
    core_start_fntt = 1'b0;
    core_start_pwm2 = 1'b0;
    core_start_intt = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          err_d   = 1'b0;
          state_d = S_LDA;
        end
      end
      S_LDA, S_LDB: begin
        in_ready = 1'b1;
        if (state == S_LDA) core_load_a_f = (cnt == '0);
        else begin
          core_load_b_f = mode_q && (cnt == '0);
          core_load_b_i = !mode_q && (cnt == ONE_C);
        end
        if (!in_valid) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          accept = 1'b1;
          if (cnt == LAST_C) begin
            state_d    = S_GAP;
            cnt_d      = '0;
            gap_next_d = (state == S_LDA) ? S_LDB : S_FNTT_P;
          end
        end
      end
      S_GAP: if (cnt == GAP_LAST) begin
        state_d = gap_next;
        cnt_d   = '0;
      end
      S_FNTT_P: begin
        core_start_fntt = 1'b1;
        core_start_ab   = mode_q;
        state_d         = S_FNTT_W;
        cnt_d           = '0;
      end
      S_PWM_P: begin
        core_start_pwm2 = 1'b1;
        state_d         = S_PWM_W;
        cnt_d           = '0;
      end
      S_INTT_P: begin
        core_start_intt = 1'b1;
        state_d         = S_INTT_W;
        cnt_d           = '0;
      end
      S_FNTT_W, S_PWM_W, S_INTT_W: begin
        if (cnt >= GAP_C && core_done) begin
          state_d    = S_GAP;
          cnt_d      = '0;
          gap_next_d = (state == S_FNTT_W) ? S_PWM_P :
                       (state == S_PWM_W)  ? S_INTT_P : S_RD_P;
        end
`ifdef KYBER_SEQ_TIMEOUT_EN
        else if (cnt == TMO_C) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
`else
        else if (cnt >= GAP_C) cnt_d = cnt;
`endif
      end
      S_RD_P: begin
        core_read_a = 1'b1;
        state_d     = S_RD_W;
        cnt_d       = '0;
      end
      S_RD_W: if (cnt == ONE_C) begin
        state_d = S_RD;
        cnt_d   = '0;
      end
      S_RD: begin
        out_valid = 1'b1;
        out_index = read_order(cnt[7:0]);
        if (cnt == LAST_C) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // p0: operand capture; HALF-mode b swaps the middle pair of every group of four
  assign rob_slot    = cnt[1:0] - 2'd1;
  assign direct_load = accept && (state == S_LDA || mode_q);
  assign half_slot   = !mode_q && ((state == S_LDB && cnt != '0 && accept) ||
                                   (state == S_GAP && gap_next == S_FNTT_P && cnt == '0));

  always_comb begin
    rob_sel = rob_p0;
    case (rob_slot)
      2'd1:    rob_sel = in_data;
      2'd2:    rob_sel = rob_p1;
      default: rob_sel = rob_p0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rob_p0 <= in_data;
      rob_p1 <= rob_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            din_p0 <= '0;
    else if (half_slot)   din_p0 <= rob_sel;
    else if (direct_load) din_p0 <= in_data;
    else                  din_p0 <= '0;
  end

  assign core_din      = din_p0;
  assign out_data      = out_valid ? core_dout : '0;
  assign busy          = (state != S_IDLE);
  assign err           = err_q;
  assign core_read_b   = 1'b0;
  assign core_load_a_i = 1'b0;

endmodule

// File: doc/kyber_pmul_seq.md
Name: kyber_pmul_seq

Overview:
- Command-driven sequencer for the KyberHPM1PE polynomial-multiplier core.
- Accepts one command, streams two 256-coefficient operands into the core's load ports, and issues the FNTT, PWM2 and INTT start pulses in order, waiting on the core's done flag after each.
- Reads the product back as a tagged output stream.
- Replaces the hand-timed pulse sequencing currently done in benches, and is the single owner of the core's control pins.

Parameters:
- PE_NUMBER, 1, coefficients per core word; only 1 supported.
- GAP_CYCLES, 2, idle cycles between phases and after each start pulse before done is sampled.
- DONE_TIMEOUT, 4095, maximum cycles waiting for core_done (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  1  0 = HALF (b already in NTT domain), 1 = FULL (both operands in POLY domain)
- in_valid  in  1  operand coefficient present
- in_ready  out  1  sequencer consuming a coefficient this cycle
- in_data  in  12  operand coefficient: a[0..255], then b[0..255], natural order
- out_valid  out  1  product coefficient valid
- out_data  out  12  product coefficient
- out_index  out  8  coefficient index of out_data
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at end of command
- err  out  1  sticky error; cleared on next command accept
- core_load_a_f, core_load_a_i, core_load_b_f, core_load_b_i, core_read_a, core_read_b, core_start_ab, core_start_fntt, core_start_pwm2, core_start_intt  out  1 each  core control pulses
- core_din  out  12  core data in
- core_dout  in  12  core data out
- core_done  in  1  core operation complete

Behaviour:
- Reset:
  - All outputs are 0; the FSM enters IDLE and all counters clear.
  - Reset mid-operation aborts immediately. The core is not reset by this block.
- Command accept:
  - A command is accepted when cmd_valid && cmd_ready. The mode is latched and err clears.
  - cmd_valid while busy is ignored.
- FSM sequence: IDLE → LDA → GAP → LDB → GAP → FNTT_P → FNTT_W → PWM_P → PWM_W → INTT_P → INTT_W → RD_P → RD_W → RD → FIN → IDLE.
- LDA (both modes):
  - core_load_a_f pulses in window-start cycle W; in_ready is high for W..W+255.
  - core_din is in_data registered: coefficient i appears on core_din at W+1+i.
- LDB, FULL mode: identical to LDA, but pulses core_load_b_f.
- LDB, HALF mode:
  - in_ready is high for W..W+255; core_load_b_i pulses at W+1.
  - A 4-entry reorder buffer emits each group of 4 as 4k+0, 4k+2, 4k+1, 4k+3 on core_din at W+2..W+257.
- Underrun:
  - Any cycle with in_ready=1 and in_valid=0 sets err, drops in_ready, returns to IDLE without a done pulse, and leaves core_din at 0.
- Data handshake: in_valid with in_ready=0 is ignored; no coefficient is consumed.
- FNTT_P:
  - Single-cycle core_start_fntt.
  - core_start_ab is asserted in the same cycle in FULL mode and is 0 in HALF mode.
- PWM_P and INTT_P: single-cycle core_start_pwm2 and core_start_intt respectively; core_start_ab=0.
- *_W states:
  - Ignore core_done for GAP_CYCLES cycles after the pulse, then advance on the first cycle core_done=1.
  - GAP_CYCLES idle cycles follow before the next pulse.
- Readout:
  - RD_P pulses core_read_a at cycle R.
  - out_valid is high for R+3..R+258, with out_data = core_dout (combinational passthrough).
  - out_index sequence: 0, 128, 1, 129, …, 127, 255.
  - out_valid has no backpressure.
- FIN: done is high for one cycle, then IDLE.
- core_read_b and core_load_a_i are held at 0 in all modes.
- All core pulses are exactly 1 cycle and mutually exclusive, except start_ab with start_fntt.

Optional Feature:
- KYBER_SEQ_TIMEOUT_EN defined:
  - Each *_W state counts cycles after the ignore window.
  - If the count reaches DONE_TIMEOUT without core_done, err sets and the FSM returns to IDLE with no done pulse.
- KYBER_SEQ_TIMEOUT_EN not defined: the FSM waits indefinitely; no counter logic is present.

Test Plan:
- HALF golden:
  - Stimulus: DIN0 as a and DIN1_MFNTT as b, against a real core.
  - Required response: 256 out_valid beats; reassembled by out_index, all 256 match KYBER_DOUT; exactly one done pulse; err=0.
- Reorder check:
  - Stimulus: HALF mode, b[i]=i.
  - Required response: from W+2, core_din = 0,2,1,3,4,6,5,7,…,252,254,253,255; core_load_b_i seen exactly once, at W+1.
- FULL pulse order:
  - Stimulus: FULL mode with a core model that raises done 50 cycles after each start.
  - Required response: core_load_a_f, then core_load_b_f, then core_start_fntt with core_start_ab=1, then pwm2, then intt, then read_a; gaps ≥2 cycles.
- Underrun:
  - Stimulus: drop in_valid at b index 100.
  - Required response: err=1 next cycle, in_ready=0, busy=0, no start pulses, no done; a following good command clears err and completes.
- Reset mid-FNTT_W:
  - Stimulus: assert reset for 1 cycle while waiting on core_done.
  - Required response: all outputs 0 the next cycle, cmd_ready=1; a new command then completes.
- Timeout (KYBER_SEQ_TIMEOUT_EN, DONE_TIMEOUT=100):
  - Stimulus: core_done held 0.
  - Required response: err sets 100 cycles after the ignore window; FSM returns to IDLE; no done pulse.
